// File: rtl/apb_rr_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_master
// Description : Two-requester round-robin APB master. Arbitrates between two
//               valid/done requesters, runs APB SETUP/ACCESS, waits on PREADY
//               with an optional timeout and returns read data / error.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_master #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   // requester 0
   input  logic              r0_valid,
   input  logic              r0_write,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_done,
   // requester 1
   input  logic              r1_valid,
   input  logic              r1_write,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_done,
   // shared response
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   // APB
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   // Counter needs at least one bit even when the timeout is disabled.
   localparam int            CW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit            C_TO_EN     = (TIMEOUT > 0);
   localparam logic [CW-1:0] C_WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                grant_q, grant_d;
   logic                last_grant_q, last_grant_d;
   logic [CW-1:0]       wait_q, wait_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                win;

   // Next-state logic: arbitration in IDLE, PREADY/timeout handling in ACCESS.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      wait_d       = wait_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      win          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (r0_valid || r1_valid) begin
               // On a tie the requester that was not served last wins.
               win      = (r0_valid && r1_valid) ? ~last_grant_q : r1_valid;
               grant_d  = win;
               pwrite_d = win ? r1_write : r0_write;
               paddr_d  = win ? r1_addr  : r0_addr;
               pwdata_d = win ? r1_wdata : r0_wdata;
               wait_d   = '0;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (PREADY) begin
               err_d = 1'b0;
               if (!pwrite_q) begin
                  rdata_d = PRDATA;
               end
               state_d = S_DONE;
            end else if (C_TO_EN && (wait_q == C_WAIT_LAST)) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_DONE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DONE: begin
            last_grant_d = grant_q;
            wait_d       = '0;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q      <= S_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         wait_q       <= '0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         wait_q       <= wait_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   // APB control and done pulses decode directly from the state.
   always_comb begin
      PSEL    = (state_q == S_SETUP) || (state_q == S_ACCESS);
      PENABLE = (state_q == S_ACCESS);
      r0_done = (state_q == S_DONE) && !grant_q;
      r1_done = (state_q == S_DONE) &&  grant_q;
   end

   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_rr_master
// Description : Self-checking bench for apb_rr_master with a behavioural APB
//               memory, per-port expected-response queues and a done monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_rr_master;

   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic              r0_valid, r0_write, r1_valid, r1_write;
   logic [ADDR_W-1:0] r0_addr, r1_addr;
   logic [DATA_W-1:0] r0_wdata, r1_wdata;
   logic              r0_done, r1_done;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              PSEL, PENABLE, PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA, PRDATA;
   logic              PREADY;

   apb_rr_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_done(r0_done),
      .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_done(r1_done),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   // ---------------- behavioural APB memory ----------------
   logic [DATA_W-1:0] mem [1024];
   int  cnt = 0, tgt = 0;
   int  rdy_fix = 0;
   bit  rdy_rand = 1'b0;
   bit  stuck = 1'b0;

   assign PREADY = PSEL && PENABLE && !stuck && (cnt == tgt);
   assign PRDATA = mem[PADDR];

   // Memory contents are cleared by reset so the bench shadow can follow.
   always @(posedge PCLK) begin
      if (PRESET) begin
         cnt <= 0;
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
      end else if (PSEL && !PENABLE) begin
         cnt <= 0;
         tgt <= rdy_rand ? int'($urandom_range(0, 3)) : rdy_fix;
      end else if (PSEL && PENABLE) begin
         if (PREADY) begin
            if (PWRITE) mem[PADDR] <= PWDATA;
            cnt <= 0;
         end else begin
            cnt <= cnt + 1;
         end
      end
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      logic              w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              e;
   } exp_t;

   exp_t              q0[$], q1[$];
   int                order_log[$];
   logic [DATA_W-1:0] shadow [1024];
   logic [DATA_W-1:0] model_rdata = '0;
   int                n_chk = 0, n_pass = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s", name);
   endtask

   task automatic clear_shadow();
      for (int i = 0; i < 1024; i++) shadow[i] = '0;
   endtask

   // Issue one request on port p and hold it until its done pulse.
   task automatic do_req(input int p, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic exp_err, output int lat);
      exp_t e;
      int   start;
      logic got;
      e.w = w; e.a = a; e.e = exp_err;
      e.d = (exp_err || w) ? '0 : shadow[a];
      if (w && !exp_err) shadow[a] = d;
      if (p == 0) begin
         q0.push_back(e);
         r0_write = w; r0_addr = a; r0_wdata = d; r0_valid = 1'b1;
      end else begin
         q1.push_back(e);
         r1_write = w; r1_addr = a; r1_wdata = d; r1_valid = 1'b1;
      end
      start = cyc;
      got   = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(posedge PCLK); #1;
         got = (p == 0) ? r0_done : r1_done;
      end
      lat = got ? (cyc - start) : -1;
      if (!got) fail_now($sformatf("done_timeout_port%0d", p));
      @(posedge PCLK); #1;
      check($sformatf("done_single_pulse_p%0d", p), (p == 0) ? r0_done : r1_done, 0);
      if (p == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
   endtask

   task automatic mon_pop(input int p);
      exp_t e;
      if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
         fail_now($sformatf("unexpected_done_port%0d", p));
         return;
      end
      e = (p == 0) ? q0.pop_front() : q1.pop_front();
      if (e.e) model_rdata = '0;
      else if (!e.w) model_rdata = e.d;
      check($sformatf("rsp_rdata_p%0d", p), rsp_rdata, model_rdata);
      check($sformatf("rsp_err_p%0d", p), rsp_err, e.e);
      check($sformatf("paddr_pwrite_p%0d", p), {PWRITE, PADDR}, {e.w, e.a});
      check("psel_penable_in_done", {PSEL, PENABLE}, 2'b00);
      order_log.push_back(p);
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   logic              s_w;
   logic [ADDR_W-1:0] s_a;
   logic [DATA_W-1:0] s_d;
   always @(negedge PCLK) begin
      if (PRESET) begin
         model_rdata = '0;
      end else begin
         if (PENABLE && !PSEL) fail_now("penable_without_psel");
         if (PSEL && !PENABLE) begin
            s_w = PWRITE; s_a = PADDR; s_d = PWDATA;
         end
         if (PSEL && PENABLE)
            check("apb_fields_stable", {PWRITE, PADDR, PWDATA}, {s_w, s_a, s_d});
         if (r0_done && r1_done) fail_now("both_done");
         if (r0_done) mon_pop(0);
         if (r1_done) mon_pop(1);
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_apb_ctl"}, {PSEL, PENABLE, PWRITE}, 3'b000);
      check({tag, "_paddr_pwdata"}, {PADDR, PWDATA}, '0);
      check({tag, "_done"}, {r0_done, r1_done}, 2'b00);
      check({tag, "_rsp"}, {rsp_err, rsp_rdata}, '0);
   endtask

   // Random traffic on one port, restricted to addresses of its own parity.
   task automatic rand_port(input int p, input int n);
      int          lat, gap;
      logic [31:0] tmp;
      logic [ADDR_W-1:0] a;
      for (int i = 0; i < n; i++) begin
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin @(posedge PCLK); #1; end
         tmp = $urandom_range(0, 511);
         a   = {tmp[8:0], p[0]};
         do_req(p, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, lat);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      PRESET = 1'b1;
      r0_valid = 0; r0_write = 0; r0_addr = '0; r0_wdata = '0;
      r1_valid = 0; r1_write = 0; r1_addr = '0; r1_wdata = '0;
      clear_shadow();
      repeat (2) @(posedge PCLK);
      #1;
      check_reset_outputs("reset");
      PRESET = 1'b0;
      @(posedge PCLK); #1;

      // Tie arbitration right after reset: r0 first, then alternate.
      order_log.delete();
      fork
         begin : tie_r0
            int l0;
            for (int i = 0; i < 6; i++)
               do_req(0, (i % 2) == 0, ADDR_W'(2 * (i / 2 + 1)), 32'h1111_0000 + i, 1'b0, l0);
         end
         begin : tie_r1
            int l1;
            for (int i = 0; i < 6; i++)
               do_req(1, (i % 2) == 0, (i < 2) ? 10'h3FF : ADDR_W'(2 * (i / 2) - 1),
                      (i < 2) ? 32'hDEAD_BEEF : 32'h2222_0000 + i, 1'b0, l1);
         end
      join
      check("tie_log_len", order_log.size(), 12);
      for (int i = 0; i < order_log.size() && i < 12; i++)
         check($sformatf("tie_order_%0d", i), order_log[i], i % 2);

      // Zero-wait write then read on r0.
      @(posedge PCLK); #1;
      do_req(0, 1'b1, 10'h00A, 32'h1234_5678, 1'b0, lat);
      check("zero_wait_write_lat", lat, 3);
      do_req(0, 1'b0, 10'h00A, 32'h0, 1'b0, lat);
      check("zero_wait_read_lat", lat, 3);

      // Three wait states per access.
      rdy_fix = 3;
      do_req(0, 1'b1, 10'h00C, 32'hCAFE_F00D, 1'b0, lat);
      check("wait3_write_lat", lat, 6);
      do_req(0, 1'b0, 10'h00C, 32'h0, 1'b0, lat);
      check("wait3_read_lat", lat, 6);
      do_req(1, 1'b0, 10'h3FF, 32'h0, 1'b0, lat);
      check("wait3_r1_read_lat", lat, 6);
      rdy_fix = 0;

      // Timeout with PREADY stuck low, then a normal transfer on r1.
      stuck = 1'b1;
      do_req(0, 1'b0, 10'h00A, 32'h0, 1'b1, lat);
      check("timeout_lat", lat, 2 + TIMEOUT);
      stuck = 1'b0;
      do_req(1, 1'b0, 10'h3FF, 32'h0, 1'b0, lat);
      check("after_timeout_lat", lat, 3);
      do_req(0, 1'b0, 10'h002, 32'h0, 1'b0, lat);

      // Reset during a wait state: transfer dropped, no done.
      rdy_fix = 10;
      r0_write = 1'b0; r0_addr = 10'h004; r0_wdata = '0; r0_valid = 1'b1;
      lat = 0;
      for (int i = 0; i < 20 && !(PSEL && PENABLE); i++) begin @(posedge PCLK); #1; end
      check("reached_access", {PSEL, PENABLE}, 2'b11);
      repeat (2) begin @(posedge PCLK); #1; end
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      check_reset_outputs("mid_reset");
      r0_valid = 1'b0;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      clear_shadow();
      rdy_fix = 0;
      @(posedge PCLK); #1;
      check("no_done_after_reset", {r0_done, r1_done}, 2'b00);

      order_log.delete();
      fork
         begin : pr_r0
            int l0;
            do_req(0, 1'b0, 10'h004, 32'h0, 1'b0, l0);
         end
         begin : pr_r1
            int l1;
            do_req(1, 1'b0, 10'h3FF, 32'h0, 1'b0, l1);
         end
      join
      check("post_reset_log_len", order_log.size(), 2);
      if (order_log.size() >= 2) begin
         check("post_reset_first", order_log[0], 0);
         check("post_reset_second", order_log[1], 1);
      end

      // Randomized concurrent traffic with random wait states.
      rdy_rand = 1'b1;
      fork
         rand_port(0, 25);
         rand_port(1, 25);
      join
      rdy_rand = 1'b0;
      repeat (3) @(posedge PCLK);
      #1;
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
